// File: rtl/cam_pkg.sv
// cam_pkg: shared camera/background-buffer definitions.
//   - RGB565 field positions
//   - default frame geometry and address width (320x240)
//   - capture FSM state encoding used by bg_stream_reader
// No ports; imported with `import cam_pkg::*;`.
package cam_pkg;

  // RGB565 field positions
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // Default frame geometry
  localparam int CAM_FRAME_W      = 320;
  localparam int CAM_FRAME_H      = 240;
  localparam int CAM_FRAME_PIXELS = CAM_FRAME_W * CAM_FRAME_H;
  localparam int CAM_ADDR_WIDTH   = 17;
  localparam int CAM_PIXEL_WIDTH  = 16;

  // Capture FSM states
  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_LOAD  = 2'd2
  } cap_state_e;

  // State the capture FSM leaves reset in
  function automatic cap_state_e cap_reset_state(input int auto_load);
    return (auto_load != 0) ? CAP_ARMED : CAP_IDLE;
  endfunction

endpackage

// File: rtl/bg_wb_forward.sv
// bg_wb_forward: history of the last WB_DEPTH background write-backs and a
// priority match against a lookup address.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_enable             history only shifts on enabled cycles
//   i_wr_en/addr/data    snooped updater write (also the highest-priority match)
//   i_lookup_addr        aligned address about to be registered at the output
//   i_rd_data            BRAM data for that address
//   o_fwd_data           newest matching write-back, else i_rd_data
module bg_wb_forward #(
  parameter int ADDR_WIDTH  = 17,
  parameter int PIXEL_WIDTH = 16,
  parameter int WB_DEPTH    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_wr_en,
  input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
  input  logic [PIXEL_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0]  i_lookup_addr,
  input  logic [PIXEL_WIDTH-1:0] i_rd_data,
  output logic [PIXEL_WIDTH-1:0] o_fwd_data
);

  // Index 0 is the newest entry.
  logic                   r_valid [WB_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_addr  [WB_DEPTH];
  logic [PIXEL_WIDTH-1:0] r_data  [WB_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
      end
    end else if (i_enable && i_wr_en) begin
      r_valid[0] <= 1'b1;
      r_addr[0]  <= i_wr_addr;
      r_data[0]  <= i_wr_data;
      for (int i = 1; i < WB_DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // Walk oldest to newest so later (newer) matches overwrite earlier ones;
  // the live write is applied last and therefore wins over all history.
  logic [PIXEL_WIDTH-1:0] w_sel;
  always_comb begin
    w_sel = i_rd_data;
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_addr[i] == i_lookup_addr)) w_sel = r_data[i];
    end
    if (i_wr_en && (i_wr_addr == i_lookup_addr)) w_sel = i_wr_data;
  end

  assign o_fwd_data = w_sel;

endmodule

// File: rtl/bg_stream_reader.sv
// bg_stream_reader: read side of the background frame buffer.
// Issues a BRAM read for every pixel address, delays address/pixel/active/load
// by the RAM latency so they line up with the returned background word, and
// registers all of it at the output (fixed latency RAM_LATENCY+2 enabled
// cycles). A capture FSM (IDLE/ARMED/LOAD) opens a one-frame load window.
// Build option: define BG_FWD_EN to forward in-flight write-backs
// (bg_wb_forward) into bg_pixel_out; otherwise the snoop ports are unused.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                advance qualifier: every register, including the FSM,
//                         only updates on cycles where enable=1; pulses on
//                         capture_req/frame_start are ignored otherwise
//   active_in, addr_in, live_pixel_in, frame_start, capture_req  camera side
//   bg_rd_addr / bg_rd_data                        BRAM read port
//   bg_wr_en / bg_wr_addr / bg_wr_data             snooped updater writes
//   addr_out, live_pixel_out, bg_pixel_out, active_out, load_frame_out  aligned
//   capture_busy          FSM not IDLE
//   load_done             pulse after a load window closes
module bg_stream_reader
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH   = CAM_ADDR_WIDTH,
  parameter int PIXEL_WIDTH  = CAM_PIXEL_WIDTH,
  parameter int RAM_LATENCY  = 2,
  parameter int FRAME_PIXELS = CAM_FRAME_PIXELS,
  parameter int WB_DEPTH     = 4,
  parameter int AUTO_LOAD    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   active_in,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [PIXEL_WIDTH-1:0] live_pixel_in,
  input  logic                   frame_start,
  input  logic                   capture_req,
  output logic [ADDR_WIDTH-1:0]  bg_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] bg_rd_data,
  input  logic                   bg_wr_en,
  input  logic [ADDR_WIDTH-1:0]  bg_wr_addr,
  input  logic [PIXEL_WIDTH-1:0] bg_wr_data,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [PIXEL_WIDTH-1:0] live_pixel_out,
  output logic [PIXEL_WIDTH-1:0] bg_pixel_out,
  output logic                   active_out,
  output logic                   load_frame_out,
  output logic                   capture_busy,
  output logic                   load_done
);

  localparam int DEPTH = 1 + RAM_LATENCY;
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam cap_state_e RST_STATE = cap_reset_state(AUTO_LOAD);

  // ---------------- capture FSM ----------------
  cap_state_e       r_state;
  logic [CNT_W-1:0] r_pix_cnt;
  logic             r_load_done;

  logic w_load_in;
  logic w_last_pix;
  assign w_load_in  = active_in && (r_state == CAP_LOAD);
  assign w_last_pix = active_in && (r_pix_cnt == LAST_PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_pix_cnt   <= '0;
      r_load_done <= 1'b0;
    end else if (enable) begin
      r_load_done <= 1'b0;
      case (r_state)
        CAP_IDLE: begin
          // frame_start in the same cycle is ignored: load begins next frame
          if (capture_req) r_state <= CAP_ARMED;
        end
        CAP_ARMED: begin
          if (frame_start) begin
            r_state   <= CAP_LOAD;
            r_pix_cnt <= '0;
          end
        end
        CAP_LOAD: begin
          // The pixel that hits the count limit is still loaded (w_load_in
          // is evaluated from the current state).
          if (frame_start || w_last_pix) begin
            r_state     <= CAP_IDLE;
            r_load_done <= 1'b1;
          end
          if (active_in && (r_pix_cnt != LAST_PIX)) r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
        default: r_state <= CAP_IDLE;
      endcase
    end
  end

  assign capture_busy = (r_state != CAP_IDLE);
  assign load_done    = r_load_done;

  // ---------------- read stage + side pipeline ----------------
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [ADDR_WIDTH-1:0]  r_addr_p [DEPTH];
  logic [PIXEL_WIDTH-1:0] r_pix_p  [DEPTH];
  logic                   r_act_p  [DEPTH];
  logic                   r_load_p [DEPTH];

  logic [ADDR_WIDTH-1:0]  r_addr_out;
  logic [PIXEL_WIDTH-1:0] r_live_out;
  logic [PIXEL_WIDTH-1:0] r_bg_out;
  logic                   r_act_out;
  logic                   r_load_out;

  logic [PIXEL_WIDTH-1:0] w_bg_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_p[i] <= '0;
        r_pix_p[i]  <= '0;
        r_act_p[i]  <= 1'b0;
        r_load_p[i] <= 1'b0;
      end
      r_addr_out <= '0;
      r_live_out <= '0;
      r_bg_out   <= '0;
      r_act_out  <= 1'b0;
      r_load_out <= 1'b0;
    end else if (enable) begin
      r_rd_addr   <= addr_in;
      r_addr_p[0] <= addr_in;
      r_pix_p[0]  <= live_pixel_in;
      r_act_p[0]  <= active_in;
      r_load_p[0] <= w_load_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_addr_p[i] <= r_addr_p[i-1];
        r_pix_p[i]  <= r_pix_p[i-1];
        r_act_p[i]  <= r_act_p[i-1];
        r_load_p[i] <= r_load_p[i-1];
      end
      // Last side stage lines up with bg_rd_data for the same address.
      r_addr_out <= r_addr_p[DEPTH-1];
      r_live_out <= r_pix_p[DEPTH-1];
      r_act_out  <= r_act_p[DEPTH-1];
      r_load_out <= r_load_p[DEPTH-1];
      r_bg_out   <= w_bg_sel;
    end
  end

`ifdef BG_FWD_EN
  bg_wb_forward #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .WB_DEPTH    (WB_DEPTH)
  ) u_fwd (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_wr_en       (bg_wr_en),
    .i_wr_addr     (bg_wr_addr),
    .i_wr_data     (bg_wr_data),
    .i_lookup_addr (r_addr_p[DEPTH-1]),
    .i_rd_data     (bg_rd_data),
    .o_fwd_data    (w_bg_sel)
  );
`else
  assign w_bg_sel = bg_rd_data;
  // Snoop ports and history depth have no function in this build.
  logic w_unused_snoop;
  assign w_unused_snoop = ^{bg_wr_en, bg_wr_addr, bg_wr_data, 32'(WB_DEPTH)};
`endif

  assign bg_rd_addr     = r_rd_addr;
  assign addr_out       = r_addr_out;
  assign live_pixel_out = r_live_out;
  assign bg_pixel_out   = r_bg_out;
  assign active_out     = r_act_out;
  assign load_frame_out = r_load_out;

endmodule

// File: tb/tb_bg_stream_reader.sv
// tb_bg_stream_reader: directed bench for bg_stream_reader (FRAME_PIXELS=200,
// RAM_LATENCY=2, AUTO_LOAD=1). BRAM model returns data = address.
module tb_bg_stream_reader;

  localparam int AW = 17;
  localparam int PW = 16;
  localparam int RL = 2;
  localparam int FP = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          enable, active_in, frame_start, capture_req;
  logic [AW-1:0] addr_in;
  logic [PW-1:0] live_pixel_in;
  logic [AW-1:0] bg_rd_addr;
  logic [PW-1:0] bg_rd_data;
  logic          bg_wr_en;
  logic [AW-1:0] bg_wr_addr;
  logic [PW-1:0] bg_wr_data;
  logic [AW-1:0] addr_out;
  logic [PW-1:0] live_pixel_out, bg_pixel_out;
  logic          active_out, load_frame_out, capture_busy, load_done;

  bg_stream_reader #(
    .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .RAM_LATENCY(RL),
    .FRAME_PIXELS(FP), .WB_DEPTH(4), .AUTO_LOAD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .active_in(active_in),
    .addr_in(addr_in), .live_pixel_in(live_pixel_in), .frame_start(frame_start),
    .capture_req(capture_req), .bg_rd_addr(bg_rd_addr), .bg_rd_data(bg_rd_data),
    .bg_wr_en(bg_wr_en), .bg_wr_addr(bg_wr_addr), .bg_wr_data(bg_wr_data),
    .addr_out(addr_out), .live_pixel_out(live_pixel_out), .bg_pixel_out(bg_pixel_out),
    .active_out(active_out), .load_frame_out(load_frame_out),
    .capture_busy(capture_busy), .load_done(load_done)
  );

  // BRAM model: latency 2 from bg_rd_addr, stalls with enable, data = addr
  logic [PW-1:0] ram_p1, ram_p2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_p1 <= '0;
      ram_p2 <= '0;
    end else if (enable) begin
      ram_p1 <= bg_rd_addr[PW-1:0];
      ram_p2 <= ram_p1;
    end
  end
  assign bg_rd_data = ram_p2;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int load_seen = 0;
  int done_seen = 0;
  logic [AW+2*PW:0] exp_q[$];  // {active, addr, live, bg}

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic act, input logic [AW-1:0] a,
                      input logic [PW-1:0] pix, input logic fs, input logic cr,
                      input logic we, input logic [AW-1:0] wa, input logic [PW-1:0] wd,
                      input logic [PW-1:0] exp_bg);
    logic [AW+2*PW:0] e;
    enable = en; active_in = act; addr_in = a; live_pixel_in = pix;
    frame_start = fs; capture_req = cr;
    bg_wr_en = we; bg_wr_addr = wa; bg_wr_data = wd;
    @(posedge clk);
    #1;
    if (en) begin
      check_val("bg_rd_addr", 32'(bg_rd_addr), 32'(a));
      exp_q.push_back({act, a, pix, exp_bg});
      if (exp_q.size() == RL + 2) begin
        e = exp_q.pop_front();
        check_val("active_out",     32'(active_out),     32'(e[AW+2*PW]));
        check_val("addr_out",       32'(addr_out),       32'(e[AW+2*PW-1:2*PW]));
        check_val("live_pixel_out", 32'(live_pixel_out), 32'(e[2*PW-1:PW]));
        check_val("bg_pixel_out",   32'(bg_pixel_out),   32'(e[PW-1:0]));
      end
      if (load_frame_out) load_seen++;
      if (load_done) done_seen++;
    end
  endtask

  task automatic px(input logic act, input logic [AW-1:0] a);
    step(1'b1, act, a, a[PW-1:0] ^ 16'hA5A5, 1'b0, 1'b0, 1'b0, '0, '0, a[PW-1:0]);
  endtask

  task automatic ctl(input logic fs, input logic cr);
    step(1'b1, 1'b0, '0, 16'hA5A5, fs, cr, 1'b0, '0, '0, 16'h0000);
  endtask

  task automatic flush();
    for (int i = 0; i < 6; i++) px(1'b0, '0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_addr_out"},   32'(addr_out), 32'h0);
    check_val({pfx, "_live_out"},   32'(live_pixel_out), 32'h0);
    check_val({pfx, "_bg_out"},     32'(bg_pixel_out), 32'h0);
    check_val({pfx, "_active_out"}, 32'(active_out), 32'h0);
    check_val({pfx, "_load_out"},   32'(load_frame_out), 32'h0);
    check_val({pfx, "_load_done"},  32'(load_done), 32'h0);
    check_val({pfx, "_bg_rd_addr"}, 32'(bg_rd_addr), 32'h0);
    check_val({pfx, "_busy"},       32'(capture_busy), 32'h1);
  endtask

  function automatic logic [PW-1:0] fwd_exp(input logic [AW-1:0] a);
`ifdef BG_FWD_EN
    if (a == 17'd3) return 16'hF800;
    if (a == 17'd5) return 16'h07E0;
    if (a == 17'd6) return 16'h2222;
`endif
    return a[PW-1:0];
  endfunction

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    enable = 1'b0; active_in = 1'b0; addr_in = '0; live_pixel_in = '0;
    frame_start = 1'b0; capture_req = 1'b0;
    bg_wr_en = 1'b0; bg_wr_addr = '0; bg_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: outputs 0, FSM ARMED (AUTO_LOAD=1)
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Address ramp, enable always on
    for (int i = 0; i < 20; i++) px(1'b1, AW'(i));

    // Ramp with enable toggling; disabled cycles carry junk inputs
    for (int i = 20; i < 40; i++) begin
      px(1'b1, AW'(i));
      step(1'b0, 1'b1, 17'h1FFFF, 16'hDEAD, 1'b1, 1'b1, 1'b0, '0, '0, 16'h0);
    end

    // Auto-load frame longer than FRAME_PIXELS: window closes at pixel 199
    load_seen = 0; done_seen = 0;
    ctl(1'b1, 1'b0);
    for (int i = 0; i < FP + 10; i++) px(1'b1, AW'(i));
    flush();
    check_val("auto_load_pixels", 32'(load_seen), 32'(FP));
    check_val("auto_load_done",   32'(done_seen), 32'd1);
    check_val("auto_load_busy",   32'(capture_busy), 32'd0);

    // capture_req while enable=0 is not sampled
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 16'h0);
    check_val("req_disabled_busy", 32'(capture_busy), 32'd0);

    // Manual capture, second request while ARMED ignored, frame_start ends load
    ctl(1'b0, 1'b1);
    check_val("req_idle_busy", 32'(capture_busy), 32'd1);
    ctl(1'b0, 1'b1);
    load_seen = 0; done_seen = 0;
    ctl(1'b1, 1'b0);
    check_val("load_busy", 32'(capture_busy), 32'd1);
    for (int i = 0; i < 20; i++) px(1'b1, AW'(100 + i));
    ctl(1'b1, 1'b0);
    flush();
    check_val("manual_load_pixels", 32'(load_seen), 32'd20);
    check_val("manual_load_done",   32'(done_seen), 32'd1);
    check_val("manual_end_busy",    32'(capture_busy), 32'd0);

    // capture_req and frame_start together in IDLE: ARMED only
    load_seen = 0;
    ctl(1'b1, 1'b1);
    check_val("req_fs_busy", 32'(capture_busy), 32'd1);
    for (int i = 0; i < 10; i++) px(1'b1, AW'(i));
    flush();
    check_val("req_fs_no_load", 32'(load_seen), 32'd0);
    check_val("req_fs_armed",   32'(capture_busy), 32'd1);

    // Reset asserted mid-load after 100 pixels
    ctl(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) px(1'b1, AW'(i));
    check_val("midload_load_out", 32'(load_frame_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midload_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    load_seen = 0; done_seen = 0;
    for (int i = 0; i < 20; i++) px(1'b1, AW'(i));
    flush();
    check_val("post_rst_done", 32'(done_seen), 32'd0);
    check_val("post_rst_load", 32'(load_seen), 32'd0);
    check_val("post_rst_busy", 32'(capture_busy), 32'd1);

    // Forwarding on an 8-pixel frame: addr 3 from history, addr 5 from the
    // live write, addr 6 written twice (newest wins)
    for (int j = 0; j < 12; j++) begin
      logic          act, we;
      logic [AW-1:0] a, wa;
      logic [PW-1:0] wd;
      act = (j < 8);
      a   = act ? AW'(j) : '0;
      we = 1'b0; wa = '0; wd = '0;
      case (j)
        4: begin we = 1'b1; wa = 17'd3; wd = 16'hF800; end
        5: begin we = 1'b1; wa = 17'd6; wd = 16'h1111; end
        7: begin we = 1'b1; wa = 17'd6; wd = 16'h2222; end
        8: begin we = 1'b1; wa = 17'd5; wd = 16'h07E0; end
        default: ;
      endcase
      step(1'b1, act, a, a[PW-1:0] ^ 16'hA5A5, 1'b0, 1'b0, we, wa, wd,
           act ? fwd_exp(a) : 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
